spi_word_packer: RTL and testbench

//  Downstream stage of the SPI reader (splitter). Takes its byte strobe and cs_n

---
 rtl/spi_word_packer_if.sv | 17 +
 rtl/spi_word_packer.sv | 64 ++++++
 tb/tb_spi_word_packer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/spi_word_packer_if.sv
// spi_word_packer_if: byte-in / word-out bus of the SPI word packer
interface spi_word_packer_if #(parameter int AW = 3);
  logic [7:0]  byte_in;
  logic        byte_vld;
  logic        cs_n;
  logic [15:0] word_out;
  logic        word_vld;
  logic        word_rdy;
  logic [AW:0] count;
  logic        frag_err;
  logic        ovf;
  logic [7:0]  ovf_cnt;
  modport master (output byte_in, byte_vld, cs_n, word_rdy,
                  input  word_out, word_vld, count, frag_err, ovf, ovf_cnt);
  modport slave  (input  byte_in, byte_vld, cs_n, word_rdy,
                  output word_out, word_vld, count, frag_err, ovf, ovf_cnt);
endinterface

// File: rtl/spi_word_packer.sv
// spi_word_packer: packs byte pairs MSB-first into 16-bit words and buffers them in a FWFT FIFO
// Define FIFO_OVF_CNT_EN to get a saturating overflow counter on ovf_cnt.
module spi_word_packer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic clk,
  input logic rst,
  spi_word_packer_if.slave bus
);
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic [7:0]    hi_reg;
  logic          half, cs_n_d, frag_err, ovf;
  logic          vld, push, pop, accept, cs_end, half_nx;
  always_comb begin
    vld     = cnt != '0;
    push    = bus.byte_vld & half;
    pop     = vld & bus.word_rdy;
    accept  = push & ((cnt < (AW+1)'(DEPTH)) | pop);
    half_nx = bus.byte_vld ? ~half : half;
    cs_end  = bus.cs_n & ~cs_n_d;
  end
  assign bus.word_vld = vld;
  assign bus.word_out = vld ? mem[rd_ptr] : 16'h0000;
  assign bus.count    = cnt;
  assign bus.frag_err = frag_err;
  assign bus.ovf      = ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      hi_reg   <= 8'h00;
      half     <= 1'b0;
      cs_n_d   <= 1'b1;
      frag_err <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      cs_n_d <= bus.cs_n;
      if (bus.byte_vld & ~half) hi_reg <= bus.byte_in;
      // a frame ending on an unpaired byte drops it so it cannot leak into the next frame
      half     <= half_nx & ~cs_end;
      frag_err <= half_nx & cs_end;
      ovf      <= push & ~accept;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(accept) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (!rst && accept) mem[wr_ptr] <= {hi_reg, bus.byte_in};
`ifdef FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt;
  always_ff @(posedge clk) begin
    if (rst) ovf_cnt <= 8'h00;
    else if (ovf && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'h01;
  end
  assign bus.ovf_cnt = ovf_cnt;
`else
  assign bus.ovf_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_spi_word_packer.sv
// tb_spi_word_packer: directed and random checks of spi_word_packer against a queue model
module tb_spi_word_packer;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  logic [15:0] q[$];
  int pend = -1;
  logic pcs = 1'b1;
  int mcnt = 0;
  spi_word_packer_if #(.AW(3)) bus ();
  spi_word_packer #(.DEPTH(DEPTH), .AW(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic bv, input logic [7:0] b, input logic cs, input logic rdy);
    bit pop, done, ef, eo;
    logic [15:0] w;
    ef = 0; eo = 0; done = 0; w = '0;
    rst = r; bus.byte_vld = bv; bus.byte_in = b; bus.cs_n = cs; bus.word_rdy = rdy;
    if (r) begin
      q.delete(); pend = -1; pcs = 1'b1; mcnt = 0;
    end else begin
      pop = q.size() > 0 && rdy;
      if (bv) begin
        if (pend < 0) pend = int'(b);
        else begin w = {pend[7:0], b}; pend = -1; done = 1; end
      end
      if (cs && !pcs && pend >= 0) begin pend = -1; ef = 1; end
      pcs = cs;
      if (pop) void'(q.pop_front());
      if (done) begin
        if (q.size() < DEPTH) q.push_back(w);
        else eo = 1;
      end
      if (eo && mcnt < 255) mcnt++;
    end
    @(posedge clk); #1;
    chk("word_vld", bus.word_vld, q.size() > 0);
    chk("count", bus.count, q.size());
    if (q.size() > 0) chk("word_out", bus.word_out, q[0]);
    chk("frag_err", bus.frag_err, ef);
    chk("ovf", bus.ovf, eo);
`ifdef FIFO_OVF_CNT_EN
    chk("ovf_cnt", bus.ovf_cnt, mcnt);
`else
    chk("ovf_cnt", bus.ovf_cnt, 0);
`endif
  endtask
  initial begin
    logic cs;
    rst = 1'b1; bus.byte_vld = 1'b0; bus.byte_in = 8'h00; bus.cs_n = 1'b1; bus.word_rdy = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cyc(1, i[0] == 1'b0, 8'h5A, 1, 1);
    chk("rst_count", bus.count, 0);
    chk("rst_vld", bus.word_vld, 0);
    // pack one pair
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 1, 8'hA5, 0, 1);
    chk("t2_vld_early", bus.word_vld, 0);
    cyc(0, 1, 8'h3C, 0, 1);
    chk("t2_word", bus.word_out, 16'hA53C);
    cyc(0, 0, 8'h00, 0, 1);
    chk("t2_drained", bus.count, 0);
    cyc(0, 0, 8'h00, 1, 1);
    // odd-length frame
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 1, 8'h11, 0, 0);
    cyc(0, 1, 8'h22, 0, 0);
    cyc(0, 1, 8'h33, 0, 0);
    chk("t3_word", bus.word_out, 16'h1122);
    cyc(0, 0, 8'h00, 1, 1);
    chk("t3_frag", bus.frag_err, 1);
    cyc(0, 0, 8'h00, 0, 1);
    chk("t3_frag_pulse", bus.frag_err, 0);
    cyc(0, 1, 8'h44, 0, 1);
    cyc(0, 1, 8'h55, 0, 0);
    chk("t3_next", bus.word_out, 16'h4455);
    cyc(0, 0, 8'h00, 1, 1);
    // second byte coincides with frame end
    cyc(0, 1, 8'h66, 0, 1);
    cyc(0, 1, 8'h77, 1, 0);
    chk("t4_word", bus.word_out, 16'h6677);
    chk("t4_nofrag", bus.frag_err, 0);
    cyc(0, 0, 8'h00, 1, 1);
    // overflow
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 8'(i), 0, 0);
      cyc(0, 1, 8'hB0 + 8'(i), 0, 0);
    end
    chk("t5_full", bus.count, 8);
    chk("t5_ovf", bus.ovf, 1);
`ifdef FIFO_OVF_CNT_EN
    chk("t5_ovf_cnt", bus.ovf_cnt, 1);
`else
    chk("t5_ovf_cnt", bus.ovf_cnt, 0);
`endif
    cyc(0, 0, 8'h00, 0, 0);
    chk("t5_ovf_pulse", bus.ovf, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t5_drain", bus.word_out, {8'(i), 8'hB0 + 8'(i)});
      cyc(0, 0, 8'h00, 0, 1);
    end
    chk("t5_empty", bus.count, 0);
    // push and pop together while full
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'hC0 + 8'(i), 0, 0);
    cyc(0, 1, 8'hEE, 0, 0);
    cyc(0, 1, 8'hFF, 0, 1);
    chk("t6_count", bus.count, 8);
    chk("t6_noovf", bus.ovf, 0);
    // random stress
    cs = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) cs = ~cs;
      cyc(0, 1'($urandom_range(1)), 8'($urandom), cs,
          (i < 750) ? ($urandom_range(9) < 3) : ($urandom_range(9) < 7));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
